missile_ctrl: RTL

Single-missile flight controller that sits directly downstream of the player tank block. Consumes the tank's fire strobe, launch coordinates and facing direction, then advances one missile per frame across the 256×256 playfield. Terminates flight on a collision report or playfield edge, and plays a fixed-length explosion. Outputs position, direction and state flags to the sprite renderer and the collision detector.

---
 rtl/tank_pkg.sv | 21 ++
 rtl/missile_step.sv | 54 +++++
 rtl/missile_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank/missile types and playfield bounds
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_ARM  = 2'b01,
        MS_FLY  = 2'b10,
        MS_BOOM = 2'b11
    } missile_state_e;

    localparam int PF_X_MAX = 256;
    localparam int PF_Y_MAX = 256;

endpackage

// File: rtl/missile_step.sv
// rtl/missile_step.sv - combinational one-frame missile advance with playfield edge test
module missile_step
    import tank_pkg::*;
#(
    parameter int STEP  = 4,
    parameter int SIZE  = 4,
    parameter int X_MAX = PF_X_MAX,
    parameter int Y_MAX = PF_Y_MAX
) (
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  dir_e       i_dir,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_out_of_field
);

    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] SIZE11 = 11'(SIZE);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);
    localparam logic [9:0]  STEP10 = 10'(STEP);

    // 11-bit sums keep far-edge tests free of 10-bit wrap
    logic [10:0] w_x_far;
    logic [10:0] w_y_far;
    assign w_x_far = {1'b0, i_x} + SIZE11 + STEP11;
    assign w_y_far = {1'b0, i_y} + SIZE11 + STEP11;

    always_comb begin
        o_x            = i_x;
        o_y            = i_y;
        o_out_of_field = 1'b0;
        case (i_dir)
            DIR_UP: begin
                o_out_of_field = ({1'b0, i_y} < STEP11);
                o_y            = i_y - STEP10;
            end
            DIR_LEFT: begin
                o_out_of_field = ({1'b0, i_x} < STEP11);
                o_x            = i_x - STEP10;
            end
            DIR_DOWN: begin
                o_out_of_field = (w_y_far > YMAX11);
                o_y            = i_y + STEP10;
            end
            default: begin
                o_out_of_field = (w_x_far > XMAX11);
                o_x            = i_x + STEP10;
            end
        endcase
    end

endmodule

// File: rtl/missile_ctrl.sv
// rtl/missile_ctrl.sv - single-missile flight controller: launch, fly, explode
module missile_ctrl
    import tank_pkg::*;
#(
    parameter int MISSILE_STEP   = 4,
    parameter int MISSILE_SIZE   = 4,
    parameter int FIELD_X_MAX    = PF_X_MAX,
    parameter int FIELD_Y_MAX    = PF_Y_MAX,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       Missile_on,
    input  logic [9:0] Xstart,
    input  logic [9:0] Ystart,
    input  logic [1:0] TankType,
    input  logic       Missile_Hit,
    output logic [9:0] MissileX,
    output logic [9:0] MissileY,
    output logic [1:0] Missile_Dir,
    output logic       Missile_Active,
    output logic       Explosion_on,
    output logic [2:0] Explosion_Frame
);

    localparam logic [2:0] LAST_FRAME = 3'(EXPLODE_FRAMES - 1);

    missile_state_e r_state;
    missile_state_e w_state_next;
    logic           r_fire_q;
    logic [9:0]     r_x;
    logic [9:0]     r_y;
    dir_e           r_dir;
    logic [2:0]     r_frame;

    logic       w_launch;
    logic [9:0] w_step_x;
    logic [9:0] w_step_y;
    logic       w_out;

    assign w_launch = Missile_on & ~r_fire_q;

    missile_step #(
        .STEP  (MISSILE_STEP),
        .SIZE  (MISSILE_SIZE),
        .X_MAX (FIELD_X_MAX),
        .Y_MAX (FIELD_Y_MAX)
    ) u_step (
        .i_x            (r_x),
        .i_y            (r_y),
        .i_dir          (r_dir),
        .o_x            (w_step_x),
        .o_y            (w_step_y),
        .o_out_of_field (w_out)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MS_IDLE: if (w_launch) w_state_next = MS_ARM;
            MS_ARM:  w_state_next = MS_FLY;
            MS_FLY:  if (Missile_Hit || w_out) w_state_next = MS_BOOM;
            MS_BOOM: if (r_frame == LAST_FRAME) w_state_next = MS_IDLE;
            default: w_state_next = MS_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= MS_IDLE;
            r_fire_q <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_dir    <= DIR_UP;
            r_frame  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_fire_q <= Missile_on;
            case (r_state)
                MS_ARM: begin
                    r_x   <= Xstart;
                    r_y   <= Ystart;
                    r_dir <= dir_e'(TankType);
                end
                MS_FLY: begin
                    // hit or edge freezes the missile where it was drawn last
                    if (!Missile_Hit && !w_out) begin
                        r_x <= w_step_x;
                        r_y <= w_step_y;
                    end
                end
                MS_BOOM: r_frame <= (r_frame == LAST_FRAME) ? 3'd0 : r_frame + 3'd1;
                default: ;
            endcase
        end
    end

    assign MissileX        = r_x;
    assign MissileY        = r_y;
    assign Missile_Dir     = r_dir;
    assign Missile_Active  = (r_state == MS_FLY);
    assign Explosion_on    = (r_state == MS_BOOM);
    assign Explosion_Frame = r_frame;

endmodule
